m_stopwatch_cnt: RTL
====================

Name: m_stopwatch_cnt

Overview:
Stopwatch time-keeping core and consumer of the 10 ms timebase produced by the clock divider. It counts rising edges of clk10ms into a BCD MM:SS.cc value and is controlled by start/stop and clear inputs. The digit outputs feed the 7-segment display driver directly.

Parameters:
P_MAX_MIN, 59, highest minute value before wrap to 00:00.00. Legal range 1..99.

Ports:
clk  input  1  system clock, 50 MHz.
rst  input  1  asynchronous reset, active-low.
clk10ms  input  1  10 ms timebase from the divider. May be a 1-cycle pulse or a square wave; only its rising edge counts.
i_start_stop  input  1  start/stop request, synchronous to clk. Rising edge is the event.
i_clear  input  1  clear request, synchronous to clk. Rising edge is the event.
i_lap  input  1  lap request, synchronous to clk. Rising edge is the event. Used only with STOPWATCH_LAP_EN.
o_cs1  output  4  centiseconds ones, BCD.
o_cs10  output  4  centiseconds tens, BCD.
o_s1  output  4  seconds ones, BCD.
o_s10  output  4  seconds tens, BCD, 0..5.
o_m1  output  4  minutes ones, BCD.
o_m10  output  4  minutes tens, BCD.
o_running  output  1  high in RUN state.
o_wrap  output  1  1-cycle pulse when the count wraps from max to zero.

Behaviour:
- Reset (rst=0, async): all digits 0, o_running=0, o_wrap=0, state IDLE, all edge-detect registers 0, lap freeze cleared.
- Edge detect: each of clk10ms, i_start_stop, i_clear, i_lap has a delay register d. An event is x & ~d, evaluated at the clk posedge.
  - A clk10ms held high for N cycles yields one tick.
- Latency: a tick or command sampled at posedge k updates the outputs at posedge k. The new value is visible after edge k, which is 1 cycle after clk10ms is first driven high.
- FSM states: IDLE, RUN, STOP.
  - IDLE + start_stop → RUN.
  - RUN + start_stop → STOP.
  - STOP + start_stop → RUN (resume, count kept).
  - STOP or IDLE + clear → IDLE, all digits 0.
  - RUN + clear is ignored.
- Counting happens only when the current state is RUN and a tick occurs. "Current state" means the state before this edge's transition.
  - start_stop in the same cycle as a tick while IDLE: no increment.
  - start_stop in the same cycle as a tick while RUN: increment, then STOP.
- Clear has priority over start_stop in the same cycle: go to IDLE, digits 0, start_stop discarded.
- Carry chain (ripple within a single cycle):
  - cs1 9→0 carries to cs10.
  - cs10 9→0 carries to s1.
  - s1 9→0 carries to s10.
  - s10 5→0 carries to m1.
  - m1 9→0 carries to m10.
  - Minutes wrap when the minute value equals P_MAX_MIN.
- Wrap: a tick at P_MAX_MIN:59.99 gives 00:00.00 and o_wrap=1 for exactly that cycle. State stays RUN.
- Reset mid-run: immediate return to the reset values. The next tick is not counted until start_stop.

Optional Feature:
STOPWATCH_LAP_EN
- Defined:
  - A lap event in RUN toggles freeze.
  - While frozen, the o_* digits hold the snapshot taken at the lap edge, and the internal count continues.
  - A second lap event releases the freeze; the outputs show the live count from the next edge.
  - STOP does not release the freeze.
  - Clear (from STOP) releases the freeze and zeros the count.
  - Lap in IDLE or STOP is ignored.
  - o_wrap reflects the internal count regardless of freeze.
- Undefined: i_lap is ignored (edge register may be optimised out). Digits always show the live count.

Test Plan:
1. Drive rst=0 mid-simulation with clk10ms pulsing → all digits 0, o_running=0, o_wrap=0 asynchronously. After release, 10 ticks leave the count at 00:00.00.
2. start_stop pulse, then 100 one-cycle clk10ms pulses, each 4 clk apart → o_running=1, display 00:01.00. The cs1 update lands 1 clk after each clk10ms rise.
3. Square-wave clk10ms (250 clk high/250 low) for 3 periods in RUN → 00:00.03. Then start_stop → STOP, 5 more ticks → still 00:00.03. Clear in RUN earlier in the run had no effect. Clear in STOP → 00:00.00, IDLE.
4. Wrap, P_MAX_MIN=1: start, 11999 ticks → 01:59.99. One more tick → 00:00.00, o_wrap high for exactly 1 cycle, o_running=1.
5. Simultaneous events:
   - start_stop and tick in the same cycle from IDLE → 00:00.00, RUN.
   - start_stop and tick in the same cycle from RUN at 00:00.07 → 00:00.08, STOP.
   - clear and start_stop in the same cycle from STOP → IDLE, zeros.
6. With STOPWATCH_LAP_EN: RUN at 00:00.50, lap, 30 ticks → outputs 00:00.50. Lap again → 00:00.80 on the next edge. Without the macro the same stimulus shows 00:00.80 throughout the live count.

Source files
------------

// File: rtl/m_stopwatch_cnt_if.sv
// rtl/m_stopwatch_cnt_if.sv - timebase/command inputs and BCD display outputs of the stopwatch core
interface m_stopwatch_cnt_if;
    logic       clk10ms;
    logic       i_start_stop;
    logic       i_clear;
    logic       i_lap;
    logic [3:0] o_cs1;
    logic [3:0] o_cs10;
    logic [3:0] o_s1;
    logic [3:0] o_s10;
    logic [3:0] o_m1;
    logic [3:0] o_m10;
    logic       o_running;
    logic       o_wrap;

    // Controller / timebase side: drives requests, watches the display.
    modport master (
        output clk10ms, i_start_stop, i_clear, i_lap,
        input  o_cs1, o_cs10, o_s1, o_s10, o_m1, o_m10, o_running, o_wrap
    );

    // Stopwatch core side.
    modport slave (
        input  clk10ms, i_start_stop, i_clear, i_lap,
        output o_cs1, o_cs10, o_s1, o_s10, o_m1, o_m10, o_running, o_wrap
    );
endinterface

// File: rtl/m_stopwatch_cnt.sv
// rtl/m_stopwatch_cnt.sv - BCD MM:SS.cc stopwatch core; optional lap freeze via STOPWATCH_LAP_EN
module m_stopwatch_cnt #(
    parameter int P_MAX_MIN = 59
) (
    input  logic          clk,
    input  logic          rst,
    m_stopwatch_cnt_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam logic [3:0] MAX_M1  = 4'(P_MAX_MIN % 10);
    localparam logic [3:0] MAX_M10 = 4'(P_MAX_MIN / 10);

    logic [1:0] state;
    logic [1:0] state_next;

    logic tick_d;
    logic ss_d;
    logic clr_d;

    logic tick_ev;
    logic ss_ev;
    logic clr_ev;

    logic [3:0] cs1, cs10, s1, s10, m1, m10;
    logic [3:0] n_cs1, n_cs10, n_s1, n_s10, n_m1, n_m10;

    logic       inc;
    logic       clr_now;
    logic       wrap_next;
    logic       wrap_q;

    logic [23:0] live_next;
    logic [23:0] live;
    logic [23:0] shown;

    assign tick_ev = bus.clk10ms & ~tick_d;
    assign ss_ev   = bus.i_start_stop & ~ss_d;
    assign clr_ev  = bus.i_clear & ~clr_d;

    // Counting and clearing act on the state held before this edge.
    assign inc     = (state == ST_RUN) & tick_ev;
    assign clr_now = clr_ev & (state != ST_RUN);

    // Input edge-detect delay registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_d <= 1'b0;
            ss_d   <= 1'b0;
            clr_d  <= 1'b0;
        end else begin
            tick_d <= bus.clk10ms;
            ss_d   <= bus.i_start_stop;
            clr_d  <= bus.i_clear;
        end
    end

    // Control FSM: clear (outside RUN) beats start/stop; start/stop toggles run.
    always_comb begin
        state_next = state;
        if (clr_now) begin
            state_next = ST_IDLE;
        end else if (ss_ev) begin
            case (state)
                ST_IDLE: state_next = ST_RUN;
                ST_RUN:  state_next = ST_STOP;
                ST_STOP: state_next = ST_RUN;
                default: state_next = ST_IDLE;
            endcase
        end else if (state == 2'd3) begin
            state_next = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Single-cycle BCD ripple increment with minute wrap at P_MAX_MIN:59.99.
    always_comb begin
        n_cs1     = cs1;
        n_cs10    = cs10;
        n_s1      = s1;
        n_s10     = s10;
        n_m1      = m1;
        n_m10     = m10;
        wrap_next = 1'b0;
        if (inc) begin
            if (cs1 != 4'd9) begin
                n_cs1 = cs1 + 4'd1;
            end else begin
                n_cs1 = 4'd0;
                if (cs10 != 4'd9) begin
                    n_cs10 = cs10 + 4'd1;
                end else begin
                    n_cs10 = 4'd0;
                    if (s1 != 4'd9) begin
                        n_s1 = s1 + 4'd1;
                    end else begin
                        n_s1 = 4'd0;
                        if (s10 != 4'd5) begin
                            n_s10 = s10 + 4'd1;
                        end else begin
                            n_s10 = 4'd0;
                            if ((m10 == MAX_M10) && (m1 == MAX_M1)) begin
                                n_m1      = 4'd0;
                                n_m10     = 4'd0;
                                wrap_next = 1'b1;
                            end else if (m1 != 4'd9) begin
                                n_m1 = m1 + 4'd1;
                            end else begin
                                n_m1  = 4'd0;
                                n_m10 = m10 + 4'd1;
                            end
                        end
                    end
                end
            end
        end
        if (clr_now) begin
            n_cs1  = 4'd0;
            n_cs10 = 4'd0;
            n_s1   = 4'd0;
            n_s10  = 4'd0;
            n_m1   = 4'd0;
            n_m10  = 4'd0;
        end
    end

    // Live count digits and the one-cycle wrap pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs1    <= 4'd0;
            cs10   <= 4'd0;
            s1     <= 4'd0;
            s10    <= 4'd0;
            m1     <= 4'd0;
            m10    <= 4'd0;
            wrap_q <= 1'b0;
        end else begin
            cs1    <= n_cs1;
            cs10   <= n_cs10;
            s1     <= n_s1;
            s10    <= n_s10;
            m1     <= n_m1;
            m10    <= n_m10;
            wrap_q <= wrap_next;
        end
    end

    assign live      = {m10, m1, s10, s1, cs10, cs1};
    assign live_next = {n_m10, n_m1, n_s10, n_s1, n_cs10, n_cs1};

`ifdef STOPWATCH_LAP_EN
    logic        lap_d;
    logic        lap_ev;
    logic        freeze;
    logic [23:0] snap;

    assign lap_ev = bus.i_lap & ~lap_d;

    // Lap toggles a display freeze in RUN; the snapshot includes this edge's tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_d  <= 1'b0;
            freeze <= 1'b0;
            snap   <= 24'd0;
        end else begin
            lap_d <= bus.i_lap;
            if (clr_now) begin
                freeze <= 1'b0;
            end else if (lap_ev && (state == ST_RUN)) begin
                freeze <= ~freeze;
                if (!freeze) begin
                    snap <= live_next;
                end
            end
        end
    end

    assign shown = freeze ? snap : live;
`else
    logic        unused_lap;
    logic [23:0] unused_live_next;

    assign unused_lap       = bus.i_lap;
    assign unused_live_next = live_next;
    assign shown            = live;
`endif

    assign {bus.o_m10, bus.o_m1, bus.o_s10, bus.o_s1, bus.o_cs10, bus.o_cs1} = shown;
    assign bus.o_running = (state == ST_RUN);
    assign bus.o_wrap    = wrap_q;

endmodule
